// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if
// Window interface between the raster pixel front end and the two
// sobel_matrix_conv instances.
//   master : the window generator (accepts pixels, drives taps/strobes)
//   slave  : the environment (supplies pixels, consumes windows, may stall)
// Signals:
//   in_valid / in_pixel / in_ready : raster pixel handshake
//   out_stall                      : downstream hold request
//   valid_data                     : one-cycle strobe, taps hold a new window
//   in_{p1a,p2,p1b,m1a,m2,m1b}_x   : X-kernel taps
//   in_{p1a,p2,p1b,m1a,m2,m1b}_y   : Y-kernel taps
//   frame_done                     : last window of the frame issued
interface sobel_window_gen_if #(
    parameter int data_size = 24
);
    logic                 in_valid;
    logic [data_size-1:0] in_pixel;
    logic                 in_ready;
    logic                 out_stall;
    logic                 valid_data;
    logic [data_size-1:0] in_p1a_x;
    logic [data_size-1:0] in_p2_x;
    logic [data_size-1:0] in_p1b_x;
    logic [data_size-1:0] in_m1a_x;
    logic [data_size-1:0] in_m2_x;
    logic [data_size-1:0] in_m1b_x;
    logic [data_size-1:0] in_p1a_y;
    logic [data_size-1:0] in_p2_y;
    logic [data_size-1:0] in_p1b_y;
    logic [data_size-1:0] in_m1a_y;
    logic [data_size-1:0] in_m2_y;
    logic [data_size-1:0] in_m1b_y;
    logic                 frame_done;

    modport master (
        input  in_valid, in_pixel, out_stall,
        output in_ready, valid_data, frame_done,
        output in_p1a_x, in_p2_x, in_p1b_x, in_m1a_x, in_m2_x, in_m1b_x,
        output in_p1a_y, in_p2_y, in_p1b_y, in_m1a_y, in_m2_y, in_m1b_y
    );

    modport slave (
        output in_valid, in_pixel, out_stall,
        input  in_ready, valid_data, frame_done,
        input  in_p1a_x, in_p2_x, in_p1b_x, in_m1a_x, in_m2_x, in_m1b_x,
        input  in_p1a_y, in_p2_y, in_p1b_y, in_m1a_y, in_m2_y, in_m1b_y
    );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Raster-scan pixel front end for the Sobel datapath. Accepts one RGB pixel
// per handshake, keeps the two previous image lines in line buffers and a
// sliding 3x3 window, and for every interior pixel presents the six non-zero
// X-kernel taps and six non-zero Y-kernel taps with a valid_data strobe.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-low reset
//   win    sobel_window_gen_if.master
//          in_valid/in_pixel/in_ready  pixel handshake (in_ready = reset && !out_stall)
//          out_stall                   downstream hold, freezes all state
//          valid_data                  one-cycle pulse per issued window
//          12 tap buses                registered, held until the next window
//          frame_done                  pulse with the window of the last pixel
// IMG_WIDTH and IMG_HEIGHT must both be at least 3; the interface instance
// must use the same data_size as this module.
module sobel_window_gen #(
    parameter int data_size  = 24,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic              clk,
    input logic              reset,
    sobel_window_gen_if.master win
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ISSUE = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_ISSUE = ROW_W'(2);

    typedef logic [data_size-1:0] pix_t;

    // lb1 holds the line two rows up, lb0 the line directly above.
    pix_t lb0 [IMG_WIDTH];
    pix_t lb1 [IMG_WIDTH];

    // Window columns 1 and 2 (index = row, 0 oldest). Column 0 after a shift
    // is exactly the old column 1, which is what the taps consume, so it is
    // never held as separate state.
    pix_t win_c1 [3];
    pix_t win_c2 [3];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic accept;
    logic issue;
    logic last_pix;
    pix_t lb0_rd;
    pix_t lb1_rd;

    logic valid_q;
    logic frame_done_q;
    pix_t x_p1a, x_p2, x_p1b, x_m1a, x_m2, x_m1b;
    pix_t y_p1a, y_p2, y_p1b, y_m1a, y_m2, y_m1b;

    assign win.in_ready = reset & ~win.out_stall;
    assign accept       = win.in_valid & win.in_ready;

    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    // Columns 0 and 1 never issue, so a window never spans a line wrap.
    assign issue    = accept && (row >= ROW_ISSUE) && (col >= COL_ISSUE);
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

    // Line buffers: contents are don't-care after reset, refilled before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= win.in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            for (int r = 0; r < 3; r++) begin
                win_c1[r] <= '0;
                win_c2[r] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_c1[r] <= win_c2[r];
            end
            win_c2[0] <= lb1_rd;
            win_c2[1] <= lb0_rd;
            win_c2[2] <= win.in_pixel;

            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Taps are taken from the window as it will look after this shift:
    // new c0 = old c1, new c1 = old c2, new c2 = {lb1, lb0, in_pixel}.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            x_p1a <= '0;  x_p2 <= '0;  x_p1b <= '0;
            x_m1a <= '0;  x_m2 <= '0;  x_m1b <= '0;
            y_p1a <= '0;  y_p2 <= '0;  y_p1b <= '0;
            y_m1a <= '0;  y_m2 <= '0;  y_m1b <= '0;
        end else begin
            valid_q      <= issue;
            frame_done_q <= issue && last_pix;
            if (issue) begin
                x_p1a <= lb1_rd;
                x_p2  <= lb0_rd;
                x_p1b <= win.in_pixel;
                x_m1a <= win_c1[0];
                x_m2  <= win_c1[1];
                x_m1b <= win_c1[2];

                y_p1a <= win_c1[2];
                y_p2  <= win_c2[2];
                y_p1b <= win.in_pixel;
                y_m1a <= win_c1[0];
                y_m2  <= win_c2[0];
                y_m1b <= lb1_rd;
            end
        end
    end

    assign win.valid_data = valid_q;
    assign win.frame_done = frame_done_q;
    assign win.in_p1a_x   = x_p1a;
    assign win.in_p2_x    = x_p2;
    assign win.in_p1b_x   = x_p1b;
    assign win.in_m1a_x   = x_m1a;
    assign win.in_m2_x    = x_m2;
    assign win.in_m1b_x   = x_m1b;
    assign win.in_p1a_y   = y_p1a;
    assign win.in_p2_y    = y_p2;
    assign win.in_p1b_y   = y_p1b;
    assign win.in_m1a_y   = y_m1a;
    assign win.in_m2_y    = y_m2;
    assign win.in_m1b_y   = y_m1b;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen
// Bench for sobel_window_gen: a 4x4 instance (a) and a 5x3 instance (b).
// The reference model stores each frame as a flat image array and derives
// every expected window directly from the image coordinates.
module tb_sobel_window_gen;

    localparam int DS = 24;
    localparam int OV = 2 + 12 * DS;

    logic clk  = 1'b0;
    logic a_rb = 1'b0;
    logic b_rb = 1'b0;

    always #5 clk = ~clk;

    sobel_window_gen_if #(.data_size(DS)) a_if ();
    sobel_window_gen_if #(.data_size(DS)) b_if ();

    sobel_window_gen #(.data_size(DS), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk   (clk),
        .reset (a_rb),
        .win   (a_if.master)
    );

    sobel_window_gen #(.data_size(DS), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk   (clk),
        .reset (b_rb),
        .win   (b_if.master)
    );

    logic [OV-1:0] a_out, b_out;
    assign a_out = {a_if.valid_data, a_if.frame_done,
                    a_if.in_p1a_x, a_if.in_p2_x, a_if.in_p1b_x,
                    a_if.in_m1a_x, a_if.in_m2_x, a_if.in_m1b_x,
                    a_if.in_p1a_y, a_if.in_p2_y, a_if.in_p1b_y,
                    a_if.in_m1a_y, a_if.in_m2_y, a_if.in_m1b_y};
    assign b_out = {b_if.valid_data, b_if.frame_done,
                    b_if.in_p1a_x, b_if.in_p2_x, b_if.in_p1b_x,
                    b_if.in_m1a_x, b_if.in_m2_x, b_if.in_m1b_x,
                    b_if.in_p1a_y, b_if.in_p2_y, b_if.in_p1b_y,
                    b_if.in_m1a_y, b_if.in_m2_y, b_if.in_m1b_y};

    int checks = 0;
    int passes = 0;

    // ---------------- reference model ----------------
    int            n_m  [2];
    int            wd   [2] = '{4, 5};
    int            ht   [2] = '{4, 3};
    logic [DS-1:0] img  [2][16];
    logic [OV-1:0] exp_out [2];

    task automatic model_step(input int d, input logic rb, input logic v,
                              input logic st, input logic [DS-1:0] pix);
        int r, c;
        logic [DS-1:0] t [3][3];
        if (!rb) begin
            n_m[d]     = 0;
            exp_out[d] = '0;
        end else begin
            exp_out[d][OV-1 -: 2] = 2'b00;
            if (v && !st) begin
                r = n_m[d] / wd[d];
                c = n_m[d] % wd[d];
                img[d][n_m[d]] = pix;
                if (r >= 2 && c >= 2) begin
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            t[rr][cc] = img[d][(r - 2 + rr) * wd[d] + (c - 2 + cc)];
                    exp_out[d] = {1'b1, (n_m[d] == wd[d] * ht[d] - 1),
                                  t[0][2], t[1][2], t[2][2], t[0][0], t[1][0], t[2][0],
                                  t[2][0], t[2][1], t[2][2], t[0][0], t[0][1], t[0][2]};
                end
                n_m[d] = (n_m[d] + 1) % (wd[d] * ht[d]);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, a_rb, a_if.in_valid, a_if.out_stall, a_if.in_pixel);
        model_step(1, b_rb, b_if.in_valid, b_if.out_stall, b_if.in_pixel);
    end

    // ---------------- drivers ----------------
    task automatic step_a(input logic v, input logic [DS-1:0] pix, input logic st, input logic rb);
        @(negedge clk);
        a_if.in_valid  = v;
        a_if.in_pixel  = pix;
        a_if.out_stall = st;
        a_rb           = rb;
        #1;
    endtask

    task automatic step_b(input logic v, input logic [DS-1:0] pix, input logic st, input logic rb);
        @(negedge clk);
        b_if.in_valid  = v;
        b_if.in_pixel  = pix;
        b_if.out_stall = st;
        b_rb           = rb;
        #1;
    endtask

    logic [12*DS-1:0] seq1 [4];

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, DS'(24'h123456), 1'b0, 1'b0);
            checks++; if (a_out !== '0) $display("FAIL reset_outputs_a: got %h want 0", a_out); else passes++;
            checks++; if (a_if.in_ready !== 1'b0) $display("FAIL reset_ready_a: got %b want 0", a_if.in_ready); else passes++;
            checks++; if (b_out !== '0) $display("FAIL reset_outputs_b: got %h want 0", b_out); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, fds = 0, first_step = -1, fd_at = -1;
        logic [12*DS-1:0] want_first;
        want_first = {DS'(2), DS'(6), DS'(10), DS'(0), DS'(4), DS'(8),
                      DS'(8), DS'(9), DS'(10), DS'(0), DS'(1), DS'(2)};
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step_a(1'b1, DS'(i), 1'b0, 1'b1);
            else        step_a(1'b0, '0, 1'b0, 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL b2b_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            checks++; if (a_if.in_ready !== 1'b1) $display("FAIL b2b_ready step %0d: got %b want 1", i, a_if.in_ready); else passes++;
            if (a_if.valid_data === 1'b1) begin
                pulses++;
                if (pulses == 1) first_step = i;
                if (pulses <= 4) seq1[pulses-1] = a_out[12*DS-1:0];
                if (pulses == 1) begin
                    checks++; if (a_out[12*DS-1:0] !== want_first) $display("FAIL b2b_first_taps: got %h want %h", a_out[12*DS-1:0], want_first); else passes++;
                end
            end
            if (a_if.frame_done === 1'b1) begin fds++; fd_at = pulses; end
        end
        checks++; if (first_step !== 11) $display("FAIL b2b_first_latency: got step %0d want 11", first_step); else passes++;
        checks++; if (pulses !== 4) $display("FAIL b2b_pulses: got %0d want 4", pulses); else passes++;
        checks++; if (fds !== 1) $display("FAIL b2b_frame_done: got %0d want 1", fds); else passes++;
        checks++; if (fd_at !== 4) $display("FAIL b2b_frame_done_pos: got pulse %0d want 4", fd_at); else passes++;
    endtask

    task automatic test_gaps();
        int pulses = 0, fds = 0, doubles = 0;
        logic prev_v = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) step_a((i % 2) == 0, DS'(i / 2), 1'b0, 1'b1);
            else        step_a(1'b0, '0, 1'b0, 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL gaps_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            if (a_if.valid_data === 1'b1) begin
                if (prev_v) doubles++;
                pulses++;
                if (pulses <= 4) begin
                    checks++; if (a_out[12*DS-1:0] !== seq1[pulses-1]) $display("FAIL gaps_seq pulse %0d: got %h want %h", pulses, a_out[12*DS-1:0], seq1[pulses-1]); else passes++;
                end
            end
            if (a_if.frame_done === 1'b1) fds++;
            prev_v = (a_if.valid_data === 1'b1);
        end
        checks++; if (pulses !== 4) $display("FAIL gaps_pulses: got %0d want 4", pulses); else passes++;
        checks++; if (fds !== 1) $display("FAIL gaps_frame_done: got %0d want 1", fds); else passes++;
        checks++; if (doubles !== 0) $display("FAIL gaps_consecutive: got %0d want 0", doubles); else passes++;
    endtask

    task automatic test_stall();
        logic qv [$];
        logic qs [$];
        logic [DS-1:0] qp [$];
        int pulses = 0, fds = 0, low_rdy = 0;
        for (int k = 0; k <= 10; k++) begin qv.push_back(1'b1); qp.push_back(DS'(k)); qs.push_back(1'b0); end
        for (int k = 0; k < 5; k++)   begin qv.push_back(1'b1); qp.push_back(DS'(11)); qs.push_back(1'b1); end
        for (int k = 11; k <= 15; k++) begin qv.push_back(1'b1); qp.push_back(DS'(k)); qs.push_back(1'b0); end
        qv.push_back(1'b0); qp.push_back('0); qs.push_back(1'b0);
        for (int i = 0; i < qv.size(); i++) begin
            step_a(qv[i], qp[i], qs[i], 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL stall_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            checks++; if (a_if.in_ready !== !qs[i]) $display("FAIL stall_ready step %0d: got %b want %b", i, a_if.in_ready, !qs[i]); else passes++;
            if (a_if.in_ready === 1'b0) low_rdy++;
            if (i == 15) begin
                checks++; if (a_if.in_p1b_x !== DS'(10)) $display("FAIL stall_hold_p1b: got %0d want 10", a_if.in_p1b_x); else passes++;
            end
            if (a_if.valid_data === 1'b1) begin
                pulses++;
                if (pulses <= 4) begin
                    checks++; if (a_out[12*DS-1:0] !== seq1[pulses-1]) $display("FAIL stall_seq pulse %0d: got %h want %h", pulses, a_out[12*DS-1:0], seq1[pulses-1]); else passes++;
                end
            end
            if (a_if.frame_done === 1'b1) fds++;
        end
        checks++; if (low_rdy !== 5) $display("FAIL stall_ready_low: got %0d want 5", low_rdy); else passes++;
        checks++; if (pulses !== 4) $display("FAIL stall_pulses: got %0d want 4", pulses); else passes++;
        checks++; if (fds !== 1) $display("FAIL stall_frame_done: got %0d want 1", fds); else passes++;
    endtask

    task automatic test_two_frames();
        int pulses = 0, fds = 0;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) step_a(1'b1, (i < 16) ? DS'(i) : DS'(100 + i - 16), 1'b0, 1'b1);
            else        step_a(1'b0, '0, 1'b0, 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL frames_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            if (a_if.valid_data === 1'b1) begin
                pulses++;
                if (pulses == 5) begin
                    checks++; if (a_if.in_p1b_x !== DS'(110)) $display("FAIL frames_f2_p1b: got %0d want 110", a_if.in_p1b_x); else passes++;
                    checks++; if (a_if.in_m1a_x !== DS'(100)) $display("FAIL frames_f2_m1a: got %0d want 100", a_if.in_m1a_x); else passes++;
                end
            end
            if (a_if.frame_done === 1'b1) fds++;
        end
        checks++; if (pulses !== 8) $display("FAIL frames_pulses: got %0d want 8", pulses); else passes++;
        checks++; if (fds !== 2) $display("FAIL frames_frame_done: got %0d want 2", fds); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int pulses = 0, fds = 0;
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, DS'(i), 1'b0, 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL midrst_pre step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
        end
        step_a(1'b1, DS'(8), 1'b0, 1'b0);
        checks++; if (a_if.in_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", a_if.in_ready); else passes++;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step_a(1'b1, DS'(i), 1'b0, 1'b1);
            else        step_a(1'b0, '0, 1'b0, 1'b1);
            if (i == 0) begin
                checks++; if (a_out !== '0) $display("FAIL midrst_zero: got %h want 0", a_out); else passes++;
            end
            checks++; if (a_out !== exp_out[0]) $display("FAIL midrst_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            if (a_if.valid_data === 1'b1) begin
                pulses++;
                if (pulses <= 4) begin
                    checks++; if (a_out[12*DS-1:0] !== seq1[pulses-1]) $display("FAIL midrst_seq pulse %0d: got %h want %h", pulses, a_out[12*DS-1:0], seq1[pulses-1]); else passes++;
                end
            end
            if (a_if.frame_done === 1'b1) fds++;
        end
        checks++; if (pulses !== 4) $display("FAIL midrst_pulses: got %0d want 4", pulses); else passes++;
        checks++; if (fds !== 1) $display("FAIL midrst_frame_done: got %0d want 1", fds); else passes++;
    endtask

    task automatic test_random();
        int acc = 0, pulses = 0, fds = 0;
        logic v, st;
        for (int i = 0; i < 3000 && acc < 48; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            step_a(v, DS'($urandom), st, 1'b1);
            checks++; if (a_out !== exp_out[0]) $display("FAIL rand_window step %0d: got %h want %h", i, a_out, exp_out[0]); else passes++;
            if (v && !st) acc++;
            if (a_if.valid_data === 1'b1) pulses++;
            if (a_if.frame_done === 1'b1) fds++;
        end
        step_a(1'b0, '0, 1'b0, 1'b1);
        checks++; if (a_out !== exp_out[0]) $display("FAIL rand_window tail: got %h want %h", a_out, exp_out[0]); else passes++;
        if (a_if.valid_data === 1'b1) pulses++;
        if (a_if.frame_done === 1'b1) fds++;
        checks++; if (acc !== 48) $display("FAIL rand_budget: accepted %0d want 48", acc); else passes++;
        checks++; if (pulses !== 12) $display("FAIL rand_pulses: got %0d want 12", pulses); else passes++;
        checks++; if (fds !== 3) $display("FAIL rand_frame_done: got %0d want 3", fds); else passes++;
    endtask

    task automatic test_small_frame();
        int pulses = 0, fds = 0;
        int pstep [3] = '{-1, -1, -1};
        logic [3*DS-1:0] last_x;
        last_x = '0;
        step_b(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) step_b(1'b1, DS'(i), 1'b0, 1'b1);
            else        step_b(1'b0, '0, 1'b0, 1'b1);
            checks++; if (b_out !== exp_out[1]) $display("FAIL small_window step %0d: got %h want %h", i, b_out, exp_out[1]); else passes++;
            if (b_if.valid_data === 1'b1) begin
                if (pulses < 3) pstep[pulses] = i;
                pulses++;
                last_x = {b_if.in_p1a_x, b_if.in_p2_x, b_if.in_p1b_x};
            end
            if (b_if.frame_done === 1'b1) fds++;
        end
        checks++; if (pulses !== 3) $display("FAIL small_pulses: got %0d want 3", pulses); else passes++;
        checks++; if (fds !== 1) $display("FAIL small_frame_done: got %0d want 1", fds); else passes++;
        // pulse at step i belongs to pixel i-1; centres (1,1),(1,2),(1,3) are pixels 12,13,14
        for (int k = 0; k < 3; k++) begin
            checks++; if (pstep[k] !== 13 + k) $display("FAIL small_centre %0d: got step %0d want %0d", k, pstep[k], 13 + k); else passes++;
        end
        checks++; if (last_x !== {DS'(4), DS'(9), DS'(14)}) $display("FAIL small_last_x: got %h want %h", last_x, {DS'(4), DS'(9), DS'(14)}); else passes++;
    endtask

    initial begin
        a_if.in_valid = 1'b0; a_if.in_pixel = '0; a_if.out_stall = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_pixel = '0; b_if.out_stall = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_stall();
        test_two_frames();
        test_reset_mid_frame();
        test_random();
        test_small_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Raster-scan pixel front end for the Sobel datapath. It accepts one RGB pixel per handshake and buffers two image lines plus a 3x3 window.
- For every interior pixel it presents the six non-zero X-kernel taps and six non-zero Y-kernel taps to the two sobel_matrix_conv instances, together with a valid_data strobe.
- It is the producer side of the window interface that the convolution units consume. It replaces the stored-image window fetch in the controller.

Parameters:
- data_size, 24, pixel width in bits (RGB).
- IMG_WIDTH, 640, pixels per line; must be at least 3.
- IMG_HEIGHT, 480, lines per frame; must be at least 3.

Ports:
- clk  in  1  Clock; all logic on the rising edge.
- reset  in  1  Synchronous, active-low reset.
- in_valid  in  1  Input pixel is valid.
- in_pixel  in  data_size  Raster-order pixel.
- in_ready  out  1  Pixel is accepted when in_valid && in_ready.
- out_stall  in  1  Downstream hold request.
- valid_data  out  1  The 12 tap buses hold a new window (one-cycle pulse per window).
- in_p1a_x, in_p2_x, in_p1b_x  out  data_size each  X taps at r0c2, r1c2, r2c2.
- in_m1a_x, in_m2_x, in_m1b_x  out  data_size each  X taps at r0c0, r1c0, r2c0.
- in_p1a_y, in_p2_y, in_p1b_y  out  data_size each  Y taps at r2c0, r2c1, r2c2.
- in_m1a_y, in_m2_y, in_m1b_y  out  data_size each  Y taps at r0c0, r0c1, r0c2.
- frame_done  out  1  One-cycle pulse when the last window of a frame is issued.

Behaviour:
- Reset (reset==0 at a clock edge):
  - col, row, window registers, valid_data, frame_done and all tap outputs go to 0.
  - Line-buffer RAM contents are don't-care; they are refilled before first use.
- in_ready = reset && !out_stall (combinational). It is 0 while reset is low.
- Storage:
  - Two line buffers, lb0 and lb1, each IMG_WIDTH x data_size, addressed by col.
  - 3x3 window register w[r][c]: r0 is the oldest line, c2 is the newest column.
- On an accepted pixel at (row, col):
  - The window shifts left one column.
  - The new right column is w[0][2]=lb1[col], w[1][2]=lb0[col], w[2][2]=in_pixel.
  - Line buffers update lb1[col]<=lb0[col], lb0[col]<=in_pixel.
  - col increments. At IMG_WIDTH-1 it wraps to 0 and row increments. At IMG_HEIGHT-1 row also wraps to 0, ready for the next frame with no gap.
- Window issue:
  - If the accepted pixel has row>=2 and col>=2, valid_data=1 on the next cycle. The tap outputs then carry the updated window, centred on pixel (row-1, col-1).
  - Otherwise valid_data=0 on the next cycle. Latency is 1 cycle from acceptance.
  - Windows never straddle a line boundary because columns 0 and 1 never issue.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Tap outputs are registered. They hold their value until the next issued window.
- frame_done is asserted in the same cycle as the valid_data for the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Stall and input gaps:
  - While out_stall=1, no pixel is accepted, no state changes, and no new valid_data is issued.
  - A valid_data already asserted in the cycle out_stall rises still completes its single cycle.
  - Gaps in in_valid (in_valid=0) freeze all state. valid_data is 0 during gap cycles.
- Reset mid-frame: everything restarts at (0,0). The partial frame is discarded and no frame_done is issued for it.
- Arithmetic: only counters. col is clog2(IMG_WIDTH) bits and row is clog2(IMG_HEIGHT) bits. Pixel data passes through unmodified.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 sent back-to-back:
  - First valid_data occurs 1 cycle after pixel 10 is accepted.
  - X taps p1a/p2/p1b=2/6/10 and m1a/m2/m1b=0/4/8.
  - Y taps p1a/p2/p1b=8/9/10 and m1a/m2/m1b=0/1/2.
  - Exactly 4 valid_data pulses in total, for pixels 10, 11, 14, 15.
  - frame_done occurs together with the 4th pulse.
- Same frame with in_valid toggled 1/0 each cycle:
  - Identical tap sequence and pulse count.
  - valid_data never high in two consecutive cycles.
- Same frame with out_stall=1 held for 5 cycles right after pixel 10 is accepted:
  - in_ready=0 for those 5 cycles.
  - Taps hold 2/6/10..., only one pulse occurs for pixel 10, and the stream then resumes correctly.
- Two frames back-to-back (pixels 0..15, then 100..115):
  - 8 pulses and 2 frame_done pulses.
  - The first window of frame 2 has X p1b=110 and m1a=100.
- Reset (reset=0) asserted for 1 cycle after pixel 7, then a full frame 0..15 is sent:
  - All outputs are 0 during reset.
  - The next 4 pulses match the first scenario exactly, with 1 frame_done.
- IMG_WIDTH=5, IMG_HEIGHT=3, pixels 0..14:
  - 3 pulses, at centres (1,1), (1,2), (1,3).
  - Last window has X p1a/p2/p1b=4/9/14.
